beep_pattern_gen: RTL and testbench
===================================

# beep_pattern_gen

Parametrised buzzer pattern sequencer that drives a piezo output through a fixed number of tone segments. On a start pulse it plays `SEG_CNT` segments of `SEG_LEN` clock cycles each, alternating between a low and a high tone, then flags completion. It sits between the game control FSM and the buzzer pin and generalises the single-pattern beep block to any segment count, length and tone pair, with abort and restart.

## Interface
- `SEG_CNT`, default 4: number of tone segments per pattern, at least 1.
- `SEG_LEN`, default 250: clock cycles per segment, at least 2.
- `DIV_LO`, default 2: half-period in clk cycles of the low tone, used by even segments, at least 1.
- `DIV_HI`, default 1: half-period in clk cycles of the high tone, used by odd segments, at least 1.
- `GAP_LEN`, default 2: silent cycles between segments. Only used with `BEEP_GAP_EN`.
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  request to begin a pattern; sampled in IDLE or DONE.
- `abort`  in  1  stop the current pattern immediately.
- `beep`  out  1  buzzer drive.
- `busy`  out  1  high while PLAY or GAP.
- `over`  out  1  pattern completed; held until next start or rst.
- `seg_idx`  out  max(1,$clog2(SEG_CNT))  index of the current segment.

## Operation
- **Reset.** All outputs are 0. The FSM goes to IDLE and all counters are cleared. `rst` overrides `start` and `abort`.
- **States.** The FSM has IDLE, PLAY, GAP and DONE. GAP exists only with the macro.
- **IDLE/DONE + start.** Go to PLAY, with `seg_idx`=0, segment counter=0, tone counter=0, `beep`=0 and `over`=0.
- **start during PLAY/GAP.** Ignored.
- **PLAY tone generation.**
  - The tone counter counts 0..H-1, with H=`DIV_LO` for an even `seg_idx` and H=`DIV_HI` for an odd one.
  - When the tone counter reaches H-1, `beep` toggles and the counter wraps to 0.
- **Segment boundaries.**
  - The segment counter counts 0..`SEG_LEN`-1.
  - On its last cycle, if `seg_idx`<`SEG_CNT`-1: increment `seg_idx` and clear the segment and tone counters.
  - At each segment boundary `beep` is forced to 0, so every segment starts low.
- **Last segment.** On the last cycle of segment `SEG_CNT`-1, go to DONE. `over`=1, `busy`=0, `beep`=0 and `seg_idx` holds at `SEG_CNT`-1.
- **abort in PLAY/GAP.** On the next edge go to IDLE, with `beep`=0, `busy`=0, `seg_idx`=0 and `over` left at 0.
  - If `abort` and `start` are both high in PLAY, `abort` wins.
  - If both are high in IDLE/DONE, `start` wins.
- **abort in IDLE/DONE.** No effect; `over` stays set.
- **Counter widths.** Counters are sized with $clog2 of their parameter and never exceed their terminal value. There is no wrap beyond the terminal value.

## Timing
- All outputs are registered.
- **Start latency.** With `start` sampled high at edge k: `busy`=1 from k+1, and the first PLAY cycle is k+1.
- **First toggle.** `beep` first rises at edge k+1+H, where H is the half-period of segment 0.
- **Pattern length, no macro.** The PLAY cycles are k+1..k+`SEG_CNT`·`SEG_LEN`. `over` rises and `busy` falls at edge k+1+`SEG_CNT`·`SEG_LEN`.
- **Abort latency.** One cycle.
- **Restart from DONE.** `over` clears at the same edge that `busy` rises.

## Configuration
- **`BEEP_GAP_EN` defined.**
  - After each segment except the last, the FSM enters GAP for `GAP_LEN` cycles, with `beep`=0 and `busy`=1.
  - `seg_idx` increments on entry to GAP. The next segment then starts in PLAY with the counters cleared.
  - Total busy cycles: `SEG_CNT`·`SEG_LEN` + (`SEG_CNT`-1)·`GAP_LEN`.
  - `abort` in GAP behaves as it does in PLAY.
- **Not defined.** GAP is not built, `GAP_LEN` is unused, and segments are back-to-back.

## Test plan
All scenarios use `SEG_CNT`=4, `SEG_LEN`=8, `DIV_LO`=2, `DIV_HI`=1.
- **Reset.** Hold `rst` 3 cycles with `start`=1 -> `beep`, `busy`, `over`, `seg_idx` all 0. Release with `start`=0 -> FSM stays IDLE.
- **Full pattern.** Pulse `start` at edge 0 -> `busy`=1 at 1.
  - Segment 0 `beep` per cycle: 0,0,1,1,0,0,1,1.
  - Segment 1: 0,1,0,1,0,1,0,1. Segments 2 and 3 repeat segments 0 and 1.
  - At 33: `over`=1, `busy`=0, `seg_idx`=3.
- **Start ignored while busy.** Pulse `start` again at edge 10 -> timing identical to the full-pattern scenario; `over` still rises at 33.
- **Abort mid-pattern.** `abort` at edge 12 -> at 13: IDLE, `beep`=0, `busy`=0, `seg_idx`=0, `over`=0. A later `start` plays the full 32 cycles.
- **Restart from DONE.** After `over`=1, pulse `start` -> the next edge gives `over`=0, `busy`=1 and `seg_idx`=0. Simultaneous `abort`=1 is ignored in this case.
- **Gap mode.** With `BEEP_GAP_EN` and `GAP_LEN`=2, pulse `start` at 0 -> `beep`=0 and `busy`=1 at cycles 9-10, 19-20 and 29-30. `over` rises at 39.

Source files
------------

// File: rtl/beep_pattern_gen.sv
// Buzzer pattern sequencer: plays SEG_CNT tone segments of SEG_LEN cycles, alternating low/high tone.
// Optional silent gaps between segments when BEEP_GAP_EN is defined.
module beep_pattern_gen #(
    parameter int unsigned SEG_CNT = 4,
    parameter int unsigned SEG_LEN = 250,
    parameter int unsigned DIV_LO  = 2,
    parameter int unsigned DIV_HI  = 1,
    parameter int unsigned GAP_LEN = 2,
    localparam int unsigned IDX_W  = (SEG_CNT > 1) ? $clog2(SEG_CNT) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic             beep,
    output logic             busy,
    output logic             over,
    output logic [IDX_W-1:0] seg_idx
);

    localparam int unsigned SEG_W    = (SEG_LEN > 1) ? $clog2(SEG_LEN) : 1;
    localparam int unsigned TONE_MAX = (DIV_LO > DIV_HI) ? DIV_LO : DIV_HI;
    localparam int unsigned TONE_W   = (TONE_MAX > 1) ? $clog2(TONE_MAX) : 1;

    localparam logic [SEG_W-1:0]  SEG_LAST     = SEG_W'(SEG_LEN - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST     = IDX_W'(SEG_CNT - 1);
    localparam logic [TONE_W-1:0] TONE_LO_LAST = TONE_W'(DIV_LO - 1);
    localparam logic [TONE_W-1:0] TONE_HI_LAST = TONE_W'(DIV_HI - 1);

`ifdef BEEP_GAP_EN
    localparam int unsigned      GAP_W    = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_LEN - 1);

    typedef enum logic [1:0] {IDLE, PLAY, GAP, DONE} state_t;
    logic [GAP_W-1:0] gap_cnt;
`else
    typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;
`endif

    state_t            state;
    logic [SEG_W-1:0]  seg_cnt;
    logic [TONE_W-1:0] tone_cnt;
    logic [TONE_W-1:0] tone_last_c;

    // Even segments use the low tone, odd segments the high tone
    assign tone_last_c = seg_idx[0] ? TONE_HI_LAST : TONE_LO_LAST;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            seg_cnt  <= '0;
            tone_cnt <= '0;
            seg_idx  <= '0;
            beep     <= 1'b0;
            busy     <= 1'b0;
            over     <= 1'b0;
`ifdef BEEP_GAP_EN
            gap_cnt  <= '0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= PLAY;
                        seg_cnt  <= '0;
                        tone_cnt <= '0;
                        seg_idx  <= '0;
                        beep     <= 1'b0;
                        busy     <= 1'b1;
                        over     <= 1'b0;
                    end
                end
                PLAY: begin
                    if (abort) begin
                        state    <= IDLE;
                        seg_cnt  <= '0;
                        tone_cnt <= '0;
                        seg_idx  <= '0;
                        beep     <= 1'b0;
                        busy     <= 1'b0;
                    end else if (seg_cnt == SEG_LAST) begin
                        // Segment boundary: every segment starts low with cleared counters
                        seg_cnt  <= '0;
                        tone_cnt <= '0;
                        beep     <= 1'b0;
                        if (seg_idx == IDX_LAST) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            over  <= 1'b1;
                        end else begin
                            seg_idx <= IDX_W'(seg_idx + 1'b1);
`ifdef BEEP_GAP_EN
                            state   <= GAP;
                            gap_cnt <= '0;
`endif
                        end
                    end else begin
                        seg_cnt <= SEG_W'(seg_cnt + 1'b1);
                        if (tone_cnt == tone_last_c) begin
                            tone_cnt <= '0;
                            beep     <= ~beep;
                        end else begin
                            tone_cnt <= TONE_W'(tone_cnt + 1'b1);
                        end
                    end
                end
`ifdef BEEP_GAP_EN
                GAP: begin
                    if (abort) begin
                        state   <= IDLE;
                        seg_idx <= '0;
                        busy    <= 1'b0;
                        gap_cnt <= '0;
                    end else if (gap_cnt == GAP_LAST) begin
                        state   <= PLAY;
                        gap_cnt <= '0;
                    end else begin
                        gap_cnt <= GAP_W'(gap_cnt + 1'b1);
                    end
                end
`endif
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    beep  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_beep_pattern_gen.sv
// Directed self-checking bench for beep_pattern_gen with SEG_CNT=4, SEG_LEN=8, DIV_LO=2, DIV_HI=1.
module tb_beep_pattern_gen;

    localparam int unsigned SEG_CNT = 4;
    localparam int unsigned SEG_LEN = 8;
    localparam int unsigned GAP_LEN = 2;
`ifdef BEEP_GAP_EN
    localparam int unsigned GAP_EFF = GAP_LEN;
`else
    localparam int unsigned GAP_EFF = 0;
`endif
    localparam int unsigned PERIOD  = SEG_LEN + GAP_EFF;
    // Edge at which over rises: 33 without gaps, 39 with GAP_LEN=2
    localparam int unsigned DONE_E  = 1 + SEG_CNT * SEG_LEN + (SEG_CNT - 1) * GAP_EFF;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic       beep;
    logic       busy;
    logic       over;
    logic [1:0] seg_idx;

    int n_checks = 0;
    int n_fail   = 0;

    beep_pattern_gen #(
        .SEG_CNT(SEG_CNT),
        .SEG_LEN(SEG_LEN),
        .DIV_LO (2),
        .DIV_HI (1),
        .GAP_LEN(GAP_LEN)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .abort  (abort),
        .beep   (beep),
        .busy   (busy),
        .over   (over),
        .seg_idx(seg_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected outputs at edge e (1 = first PLAY cycle) of a running pattern
    task automatic check_edge(input int unsigned e);
        int unsigned off, seg, pos;
        int unsigned exp_beep, exp_idx;
        if (e >= DONE_E) begin
            check("done_beep", beep, 0);
            check("done_busy", busy, 0);
            check("done_over", over, 1);
            check("done_idx", seg_idx, SEG_CNT - 1);
            return;
        end
        off = (e - 1) % PERIOD;
        seg = (e - 1) / PERIOD;
        if (off >= SEG_LEN) begin
            exp_beep = 0;
            exp_idx  = seg + 1;
        end else begin
            pos      = off;
            // Low tone: 0,0,1,1,... ; high tone: 0,1,0,1,...
            exp_beep = (seg % 2 == 0) ? (pos / 2) % 2 : pos % 2;
            exp_idx  = seg;
        end
        check($sformatf("beep_e%0d", e), beep, exp_beep);
        check($sformatf("busy_e%0d", e), busy, 1);
        check($sformatf("idx_e%0d", e), seg_idx, exp_idx);
        check($sformatf("over_e%0d", e), over, 0);
    endtask

    // Called with edge 1 of a pattern just reached; start_e/abort_e are drive edges (0 = none)
    task automatic run(input int unsigned start_e, input int unsigned abort_e);
        for (int unsigned e = 1; e <= DONE_E; e++) begin
            check_edge(e);
            if (e == DONE_E) break;
            if (abort_e != 0 && e == abort_e) begin
                abort = 1'b1;
                tick();
                abort = 1'b0;
                check("abort_beep", beep, 0);
                check("abort_busy", busy, 0);
                check("abort_idx", seg_idx, 0);
                check("abort_over", over, 0);
                tick();
                check("abort_stay_idle", busy, 0);
                return;
            end
            start = (start_e != 0 && e == start_e);
            tick();
            start = 1'b0;
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b1;
        abort = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("rst_beep", beep, 0);
        check("rst_busy", busy, 0);
        check("rst_over", over, 0);
        check("rst_idx", seg_idx, 0);
        rst   = 1'b0;
        start = 1'b0;
        tick();
        tick();
        check("idle_busy", busy, 0);
        check("idle_over", over, 0);

        // Full pattern
        start = 1'b1;
        tick();
        start = 1'b0;
        run(0, 0);

        // Restart from DONE with simultaneous abort; second start at edge 10 ignored
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("restart_over", over, 0);
        check("restart_busy", busy, 1);
        check("restart_idx", seg_idx, 0);
        run(10, 0);

        // Abort mid-pattern at edge 12
        start = 1'b1;
        tick();
        start = 1'b0;
        run(0, 12);

        // Full pattern after abort
        start = 1'b1;
        tick();
        start = 1'b0;
        run(0, 0);

        // Abort in DONE has no effect
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
        check("done_abort_over", over, 1);
        check("done_abort_busy", busy, 0);
        check("done_abort_idx", seg_idx, SEG_CNT - 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
